// File: rtl/dmac_engine.sv
`default_nettype none
// ============================================================================
// Module      : dmac_engine
// Description : Single-channel word-at-a-time DMA copy engine. Each iteration
//               reads one 32-bit word from the source address, then writes it
//               to the destination address with single-beat transactions.
//               Optional macro DMAC_ENGINE_ERR_EN enables abort-on-error for
//               non-OKAY read/write responses and the sticky error_o flag.
// Revision    : 1.0 - initial release
// ============================================================================
module dmac_engine #(
    parameter int LEN_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [31:0]      src_addr_i,
    input  logic [31:0]      dst_addr_i,
    input  logic [LEN_W-1:0] byte_len_i,
    input  logic             start_i,
    output logic             done_o,
    output logic             error_o,
    output logic             arvalid_o,
    output logic [31:0]      araddr_o,
    input  logic             arready_i,
    input  logic             rvalid_i,
    input  logic [31:0]      rdata_i,
    input  logic [1:0]       rresp_i,
    output logic             rready_o,
    output logic             awvalid_o,
    output logic [31:0]      awaddr_o,
    input  logic             awready_i,
    output logic             wvalid_o,
    output logic [31:0]      wdata_o,
    output logic [3:0]       wstrb_o,
    input  logic             wready_i,
    input  logic             bvalid_i,
    input  logic [1:0]       bresp_i,
    output logic             bready_o
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        RREQ  = 3'd1,
        RDATA = 3'd2,
        WREQ  = 3'd3,
        WRESP = 3'd4
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic [31:0]      r_src;
    logic [31:0]      r_dst;
    logic [31:0]      r_data;
    logic [LEN_W-1:0] r_rem;
    logic             r_aw_done;
    logic             r_w_done;

    logic             w_accept;
    logic             w_aw_hs;
    logic             w_w_hs;
    logic             w_last;
    logic             w_rd_err;
    logic             w_wr_err;

    assign w_accept = (r_state == IDLE) && start_i && (byte_len_i != '0);
    // Handshakes are formed from registered state only, so no ready/valid
    // input ever reaches a valid output combinationally.
    assign w_aw_hs  = (r_state == WREQ) && !r_aw_done && awready_i;
    assign w_w_hs   = (r_state == WREQ) && !r_w_done  && wready_i;
    assign w_last   = (r_rem <= LEN_W'(4));

    assign araddr_o = r_src;
    assign awaddr_o = r_dst;
    assign wdata_o  = r_data;

`ifdef DMAC_ENGINE_ERR_EN
    logic r_error;

    assign w_rd_err = (rresp_i != 2'b00);
    assign w_wr_err = (bresp_i != 2'b00);
    assign error_o  = r_error;

    // Sticky error flag: set by any non-OKAY response, cleared by a new start
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_error <= 1'b0;
        end else if (w_accept) begin
            r_error <= 1'b0;
        end else if ((r_state == RDATA && rvalid_i && w_rd_err) ||
                     (r_state == WRESP && bvalid_i && w_wr_err)) begin
            r_error <= 1'b1;
        end
    end
`else
    logic w_unused_resp;

    // Responses are deliberately ignored when error handling is compiled out
    assign w_unused_resp = ^{rresp_i, bresp_i};
    assign w_rd_err      = 1'b0;
    assign w_wr_err      = 1'b0;
    assign error_o       = 1'b0;
`endif

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state decode and per-state channel outputs
    always_comb begin
        w_next    = r_state;
        done_o    = 1'b0;
        arvalid_o = 1'b0;
        rready_o  = 1'b0;
        awvalid_o = 1'b0;
        wvalid_o  = 1'b0;
        bready_o  = 1'b0;
        case (r_state)
            IDLE: begin
                done_o = 1'b1;
                if (w_accept) w_next = RREQ;
            end
            RREQ: begin
                arvalid_o = 1'b1;
                if (arready_i) w_next = RDATA;
            end
            RDATA: begin
                rready_o = 1'b1;
                if (rvalid_i) w_next = w_rd_err ? IDLE : WREQ;
            end
            WREQ: begin
                awvalid_o = !r_aw_done;
                wvalid_o  = !r_w_done;
                if ((r_aw_done || w_aw_hs) && (r_w_done || w_w_hs)) w_next = WRESP;
            end
            WRESP: begin
                bready_o = 1'b1;
                if (bvalid_i) w_next = (w_wr_err || w_last) ? IDLE : RREQ;
            end
            default: w_next = IDLE;
        endcase
    end

    // Byte strobe: partial only for a final word shorter than four bytes
    always_comb begin
        wstrb_o = 4'hF;
        if (r_rem < LEN_W'(4)) begin
            case (r_rem[1:0])
                2'd1:    wstrb_o = 4'b0001;
                2'd2:    wstrb_o = 4'b0011;
                2'd3:    wstrb_o = 4'b0111;
                default: wstrb_o = 4'hF;
            endcase
        end
    end

    // Address/length/data datapath and write-handshake tracking
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_src     <= '0;
            r_dst     <= '0;
            r_rem     <= '0;
            r_data    <= '0;
            r_aw_done <= 1'b0;
            r_w_done  <= 1'b0;
        end else begin
            if (w_accept) begin
                r_src <= {src_addr_i[31:2], 2'b00};
                r_dst <= {dst_addr_i[31:2], 2'b00};
                r_rem <= byte_len_i;
            end
            if (r_state == RDATA && rvalid_i) begin
                r_data <= rdata_i;
            end
            if (r_state == WREQ) begin
                if (w_aw_hs) r_aw_done <= 1'b1;
                if (w_w_hs)  r_w_done  <= 1'b1;
            end else begin
                r_aw_done <= 1'b0;
                r_w_done  <= 1'b0;
            end
            // Addresses wrap naturally at 2^32
            if (r_state == WRESP && bvalid_i && !w_last && !w_wr_err) begin
                r_src <= r_src + 32'd4;
                r_dst <= r_dst + 32'd4;
                r_rem <= r_rem - LEN_W'(4);
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_dmac_engine.sv
`default_nettype none
// ============================================================================
// Module      : tb_dmac_engine
// Description : Randomized self-checking bench for dmac_engine. A memory slave
//               with random handshake delays logs every transaction; a
//               reference model derives the expected read/write lists from
//               (src, dst, len). Build with DMAC_ENGINE_ERR_EN to also
//               exercise the error-abort path.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dmac_engine;

    localparam int LEN_W = 16;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [31:0]      src_addr_i, dst_addr_i;
    logic [LEN_W-1:0] byte_len_i;
    logic             start_i;
    logic             done_o, error_o;
    logic             arvalid_o, arready_i;
    logic [31:0]      araddr_o;
    logic             rvalid_i, rready_o;
    logic [31:0]      rdata_i;
    logic [1:0]       rresp_i;
    logic             awvalid_o, awready_i;
    logic [31:0]      awaddr_o;
    logic             wvalid_o, wready_i;
    logic [31:0]      wdata_o;
    logic [3:0]       wstrb_o;
    logic             bvalid_i, bready_o;
    logic [1:0]       bresp_i;

    always #5 clk = ~clk;

    dmac_engine #(.LEN_W(LEN_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .src_addr_i(src_addr_i), .dst_addr_i(dst_addr_i),
        .byte_len_i(byte_len_i), .start_i(start_i),
        .done_o(done_o), .error_o(error_o),
        .arvalid_o(arvalid_o), .araddr_o(araddr_o), .arready_i(arready_i),
        .rvalid_i(rvalid_i), .rdata_i(rdata_i), .rresp_i(rresp_i), .rready_o(rready_o),
        .awvalid_o(awvalid_o), .awaddr_o(awaddr_o), .awready_i(awready_i),
        .wvalid_o(wvalid_o), .wdata_o(wdata_o), .wstrb_o(wstrb_o), .wready_i(wready_i),
        .bvalid_i(bvalid_i), .bresp_i(bresp_i), .bready_o(bready_o)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Memory content seen by the engine: a fixed function of the word address
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0] ^ 16'hC3A5, a[31:16] + 16'h1234};
    endfunction

    // Slave state and transaction logs
    bit          stall_ar = 1'b0;
    bit          ordered  = 1'b0;
    int          err_word = -1;
    bit          rd_pend  = 1'b0;
    logic [31:0] rd_addr  = '0;
    int          ar_n = 0, aw_n = 0, w_n = 0, b_n = 0;
    logic [31:0] ar_q[$];
    logic [31:0] aw_q[$];
    logic [31:0] wd_q[$];
    logic [3:0]  ws_q[$];

    // Memory slave: drive random handshakes on the falling edge, then record
    // the handshakes that the next rising edge will complete.
    initial begin
        arready_i = 0; rvalid_i = 0; rdata_i = '0; rresp_i = '0;
        awready_i = 0; wready_i = 0; bvalid_i = 0; bresp_i = '0;
        forever begin
            @(negedge clk);
            arready_i = stall_ar ? 1'b0 : ($urandom_range(0, 3) != 0);
            rvalid_i  = rd_pend && ($urandom_range(0, 2) != 0);
            rdata_i   = rvalid_i ? mem_word(rd_addr) : $urandom;
            rresp_i   = (rvalid_i && (ar_n - 1) == err_word) ? 2'd2 : 2'd0;
            if (ordered) begin
                awready_i = 1'b1;
                wready_i  = (aw_n > b_n);
            end else begin
                awready_i = 1'($urandom_range(0, 1));
                wready_i  = 1'($urandom_range(0, 1));
            end
            bvalid_i = (aw_n > b_n) && (w_n > b_n) && ($urandom_range(0, 1) != 0);
            bresp_i  = 2'd0;
            #1;
            if (!rst_n) begin
                rd_pend = 0; ar_n = 0; aw_n = 0; w_n = 0; b_n = 0;
            end else begin
                if (arvalid_o && arready_i) begin
                    ar_q.push_back(araddr_o); ar_n++; rd_pend = 1; rd_addr = araddr_o;
                end
                if (rvalid_i && rready_o) rd_pend = 0;
                if (awvalid_o && awready_i) begin aw_q.push_back(awaddr_o); aw_n++; end
                if (wvalid_o && wready_i) begin
                    wd_q.push_back(wdata_o); ws_q.push_back(wstrb_o); w_n++;
                end
                if (ordered && bready_o) begin
                    check("wresp_after_aw", 32'(aw_n > b_n), 32'd1);
                    check("wresp_after_w",  32'(w_n > b_n),  32'd1);
                end
                if (bvalid_i && bready_o) b_n++;
            end
        end
    end

    task automatic start_xfer(input logic [31:0] s, input logic [31:0] d, input logic [LEN_W-1:0] l);
        @(negedge clk);
        ar_q.delete(); aw_q.delete(); wd_q.delete(); ws_q.delete();
        ar_n = 0; aw_n = 0; w_n = 0; b_n = 0;
        src_addr_i = s; dst_addr_i = d; byte_len_i = l; start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0; src_addr_i = $urandom; dst_addr_i = $urandom; byte_len_i = LEN_W'($urandom);
    endtask

    task automatic wait_done(input int budget);
        int c = 0;
        while (!done_o && c < budget) begin
            @(negedge clk);
            c++;
        end
        check("done_in_budget", 32'(done_o), 32'd1);
    endtask

    // Reference model: expected word list derived from (src, dst, len)
    task automatic verify(input logic [31:0] s, input logic [31:0] d, input int l);
        int          n  = (l + 3) / 4;
        logic [31:0] sb = {s[31:2], 2'b00};
        logic [31:0] db = {d[31:2], 2'b00};
        check("ar_count", 32'(ar_q.size()), 32'(n));
        check("aw_count", 32'(aw_q.size()), 32'(n));
        check("w_count",  32'(wd_q.size()), 32'(n));
        for (int i = 0; i < n && i < ar_q.size() && i < aw_q.size() && i < wd_q.size(); i++) begin
            int          rem  = l - 4 * i;
            logic [3:0]  strb = (rem >= 4) ? 4'hF : 4'((1 << rem) - 1);
            logic [31:0] sa   = sb + 32'(4 * i);
            check("araddr", ar_q[i], sa);
            check("awaddr", aw_q[i], db + 32'(4 * i));
            check("wdata",  wd_q[i], mem_word(sa));
            check("wstrb",  32'(ws_q[i]), 32'(strb));
        end
        check("done_end",  32'(done_o),  32'd1);
        check("error_end", 32'(error_o), 32'd0);
    endtask

    task automatic xfer(input logic [31:0] s, input logic [31:0] d, input int l);
        start_xfer(s, d, LEN_W'(l));
        check("done_fall", 32'(done_o), 32'd0);
        wait_done(5000);
        verify(s, d, l);
    endtask

    initial begin
        logic [31:0] s, d;
        rst_n = 1'b0; start_i = 1'b0;
        src_addr_i = '0; dst_addr_i = '0; byte_len_i = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // Idle after reset: only done_o high
        repeat (100) begin
            @(negedge clk);
            check("idle_outputs", 32'({done_o, error_o, arvalid_o, rready_o, awvalid_o, wvalid_o, bready_o}),
                  32'(7'b1000000));
        end

        // Directed: 256-byte block and 6-byte two-word tail
        xfer(32'h1000, 32'h2000, 32'h100);
        xfer(32'h1000, 32'h2000, 6);

        // Zero-length start is ignored
        start_xfer(32'h1000, 32'h2000, '0);
        repeat (10) begin
            @(negedge clk);
            check("len0_done", 32'(done_o), 32'd1);
        end
        check("len0_no_ar", 32'(ar_q.size()), 32'd0);

        // Read-address stall with a stray start; aw accepted before w
        stall_ar = 1'b1; ordered = 1'b1;
        start_xfer(32'h3001, 32'h4002, 8);
        for (int i = 0; i < 20; i++) begin
            if (i == 5) begin
                src_addr_i = 32'h9000; byte_len_i = LEN_W'(32'h40); start_i = 1'b1;
            end else begin
                start_i = 1'b0;
            end
            @(negedge clk);
            check("stall_arvalid", 32'(arvalid_o), 32'd1);
            check("stall_araddr",  araddr_o, 32'h3000);
        end
        start_i = 1'b0; stall_ar = 1'b0;
        wait_done(2000);
        verify(32'h3001, 32'h4002, 8);
        ordered = 1'b0;

        // Randomized transfers, including wrap past 2^32
        for (int k = 0; k < 10; k++) begin
            s = (k % 3 == 0) ? (32'hFFFF_FFF0 + 32'($urandom_range(0, 15))) : $urandom;
            d = (k % 4 == 1) ? (32'hFFFF_FFF4 + 32'($urandom_range(0, 11))) : $urandom;
            xfer(s, d, $urandom_range(1, 40));
        end

        // Reset in mid-transfer abandons it
        start_xfer(32'h5000, 32'h6000, 32'h40);
        repeat (15) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midreset_outputs", 32'({done_o, error_o, arvalid_o, rready_o, awvalid_o, wvalid_o, bready_o}),
              32'(7'b1000000));
        @(negedge clk);
        rst_n = 1'b1;
        xfer(32'h5004, 32'h6008, 13);

`ifdef DMAC_ENGINE_ERR_EN
        // Read error on the second word aborts before its write
        err_word = 1;
        start_xfer(32'h7000, 32'h8000, 16);
        wait_done(2000);
        err_word = -1;
        check("err_ar_count", 32'(ar_q.size()), 32'd2);
        check("err_aw_count", 32'(aw_q.size()), 32'd1);
        check("err_w_count",  32'(wd_q.size()), 32'd1);
        check("err_flag",     32'(error_o),     32'd1);
        check("err_done",     32'(done_o),      32'd1);
        xfer(32'h7000, 32'h8000, 16);
`endif

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
